// File: rtl/packet_receiver_pkg.sv
// Shared types and sizing for the GPIO link packet receiver.
// Header layout, lane geometry and FSM/error encodings live here.
package packet_receiver_pkg;

    localparam int GBG_BITS    = 4;
    localparam int LANE_BITS   = 206;
    localparam int NUM_LANES   = 4;
    localparam int PAY_BITS    = NUM_LANES * LANE_BITS;
    localparam int HDR_BITS    = 6 + GBG_BITS;
    localparam int SYNC_STAGES = 2;
    localparam int LINK_W      = 2 + NUM_LANES;

    typedef enum logic [1:0] {
        PKT_DATA      = 2'b00,
        PKT_ACK       = 2'b01,
        PKT_READY_ACK = 2'b10,
        PKT_GAME_LOST = 2'b11
    } pkt_type_t;

    typedef enum logic [1:0] {
        ERR_HDR_PARITY  = 2'b00,
        ERR_STOP_BIT    = 2'b01,
        ERR_LANE_PARITY = 2'b10,
        ERR_TIMEOUT     = 2'b11
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_PAY    = 3'd2,
        ST_LPAR   = 3'd3,
        ST_ACCEPT = 3'd4,
        ST_ERR    = 3'd5
    } rx_state_t;

    // Even parity over type, seqNum, garbage and the parity bit itself must be zero.
    function automatic logic hdr_parity_ok(input logic [HDR_BITS-3:0] bits);
        return ~(^bits);
    endfunction

endpackage

// File: rtl/packet_receiver_if.sv
// Link-side raw inputs and decoded-packet outputs of the receiver.
// Handshake: pkt_valid and rx_error are single-cycle strobes with no ready; the consumer must capture the held pkt_* fields on the strobe.
interface packet_receiver_if;
    import packet_receiver_pkg::*;

    logic                 gpio_clk_in;
    logic                 serial_in_h;
    logic [NUM_LANES-1:0] serial_in;

    logic                 pkt_valid;
    pkt_type_t            pkt_type;
    logic                 pkt_seqNum;
    logic [GBG_BITS-1:0]  pkt_garbage;
    logic [PAY_BITS-1:0]  pkt_payload;
    logic                 rx_error;
    err_code_t            err_code;
    logic                 rx_busy;
    rx_state_t            dbg_state;

    modport master (
        output gpio_clk_in, serial_in_h, serial_in,
        input  pkt_valid, pkt_type, pkt_seqNum, pkt_garbage, pkt_payload,
        input  rx_error, err_code, rx_busy, dbg_state
    );

    modport slave (
        input  gpio_clk_in, serial_in_h, serial_in,
        output pkt_valid, pkt_type, pkt_seqNum, pkt_garbage, pkt_payload,
        output rx_error, err_code, rx_busy, dbg_state
    );

endinterface

// File: rtl/packet_receiver_gpio_sync_edge.sv
// Equal-depth synchronizers on every link wire plus a rising-edge strobe on bit 0 (link clock).
// Keeping all wires the same depth preserves lane-to-clock alignment.
module packet_receiver_gpio_sync_edge
    import packet_receiver_pkg::*;
#(
    parameter int WIDTH = LINK_W
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-2:0] lanes_sync,
    output logic             samp
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic                              clk_prev_q, clk_prev_d;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], raw};
        clk_prev_d = sync_q[SYNC_STAGES-1][0];
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync_q     <= '0;
            clk_prev_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            clk_prev_q <= clk_prev_d;
        end
    end

    assign lanes_sync = sync_q[SYNC_STAGES-1][WIDTH-1:1];
    assign samp       = sync_q[SYNC_STAGES-1][0] & ~clk_prev_q;

endmodule

// File: rtl/packet_receiver.sv
// Deframes the 6-wire GPIO link: header, optional DATA payload and lane parity,
// then presents the decoded packet for one cycle or flags a one-cycle error.
module packet_receiver
    import packet_receiver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                game_active,
    packet_receiver_if.slave    link
);

    localparam int HCNT_W = $clog2(HDR_BITS);
    localparam int PCNT_W = $clog2(LANE_BITS + 1);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [LINK_W-2:0]    lanes_sync;
    logic                 samp;
    logic                 hdr_bit;
    logic [NUM_LANES-1:0] lanes;

    packet_receiver_gpio_sync_edge #(.WIDTH(LINK_W)) u_sync (
        .clk        (clk),
        .rst_l      (rst_l),
        .raw        ({link.serial_in, link.serial_in_h, link.gpio_clk_in}),
        .lanes_sync (lanes_sync),
        .samp       (samp)
    );

    assign hdr_bit = lanes_sync[0];
    assign lanes   = lanes_sync[NUM_LANES:1];

    rx_state_t            state_q, state_d;
    logic [HCNT_W-1:0]    hdr_cnt_q, hdr_cnt_d;
    logic [HDR_BITS-2:0]  hdr_sr_q, hdr_sr_d, hdr_next;
    logic [PCNT_W-1:0]    pay_cnt_q, pay_cnt_d;
    logic [PAY_BITS-1:0]  pay_buf_q, pay_buf_d;
    logic [NUM_LANES-1:0] lane_par_q, lane_par_d;
    logic [TCNT_W-1:0]    idle_cnt_q, idle_cnt_d;

    logic                 pkt_valid_q, pkt_valid_d;
    pkt_type_t            pkt_type_q, pkt_type_d;
    logic                 pkt_seq_q, pkt_seq_d;
    logic [GBG_BITS-1:0]  pkt_gbg_q, pkt_gbg_d;
    logic [PAY_BITS-1:0]  pkt_pay_q, pkt_pay_d;
    logic                 rx_error_q, rx_error_d;
    err_code_t            err_code_q, err_code_d;
    logic                 rx_busy_q, rx_busy_d;

    // hdr_sr layout after the stop bit: [8:7] type, [6] seqNum, [5:2] garbage, [1] parity, [0] stop
    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        hdr_sr_d    = hdr_sr_q;
        pay_cnt_d   = pay_cnt_q;
        pay_buf_d   = pay_buf_q;
        lane_par_d  = lane_par_q;
        idle_cnt_d  = idle_cnt_q;
        pkt_valid_d = 1'b0;
        pkt_type_d  = pkt_type_q;
        pkt_seq_d   = pkt_seq_q;
        pkt_gbg_d   = pkt_gbg_q;
        pkt_pay_d   = pkt_pay_q;
        rx_error_d  = 1'b0;
        err_code_d  = err_code_q;
        hdr_next    = {hdr_sr_q[HDR_BITS-3:0], hdr_bit};

        if (!game_active) begin
            state_d    = ST_IDLE;
            idle_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idle_cnt_d = '0;
                    if (samp && !hdr_bit) begin
                        state_d    = ST_HDR;
                        hdr_cnt_d  = '0;
                        pay_cnt_d  = '0;
                        lane_par_d = '0;
                    end
                end
                ST_HDR: begin
                    if (samp) begin
                        hdr_sr_d  = hdr_next;
                        hdr_cnt_d = hdr_cnt_q + 1'b1;
                        if (hdr_cnt_q == HCNT_W'(HDR_BITS - 2)) begin
                            if (!hdr_next[0]) begin
                                state_d    = ST_ERR;
                                rx_error_d = 1'b1;
                                err_code_d = ERR_STOP_BIT;
                            end else if (!hdr_parity_ok(hdr_next[HDR_BITS-2:1])) begin
                                state_d    = ST_ERR;
                                rx_error_d = 1'b1;
                                err_code_d = ERR_HDR_PARITY;
                            end else if (pkt_type_t'(hdr_next[HDR_BITS-2 -: 2]) == PKT_DATA) begin
                                state_d = ST_PAY;
                            end else begin
                                state_d     = ST_ACCEPT;
                                pkt_valid_d = 1'b1;
                                pkt_type_d  = pkt_type_t'(hdr_next[HDR_BITS-2 -: 2]);
                                pkt_seq_d   = hdr_next[HDR_BITS-4];
                                pkt_gbg_d   = hdr_next[HDR_BITS-5 -: GBG_BITS];
                            end
                        end
                    end
                end
                ST_PAY: begin
                    if (samp) begin
                        pay_buf_d[{pay_cnt_q, 2'b00} +: NUM_LANES] = lanes;
                        lane_par_d = lane_par_q ^ lanes;
                        pay_cnt_d  = pay_cnt_q + 1'b1;
                        if (pay_cnt_q == PCNT_W'(LANE_BITS - 1)) begin
                            state_d = ST_LPAR;
                        end
                    end
                end
                ST_LPAR: begin
                    if (samp) begin
                        if ((lane_par_q ^ lanes) != '0) begin
                            state_d    = ST_ERR;
                            rx_error_d = 1'b1;
                            err_code_d = ERR_LANE_PARITY;
                        end else begin
                            state_d     = ST_ACCEPT;
                            pkt_valid_d = 1'b1;
                            pkt_type_d  = pkt_type_t'(hdr_sr_q[HDR_BITS-2 -: 2]);
                            pkt_seq_d   = hdr_sr_q[HDR_BITS-4];
                            pkt_gbg_d   = hdr_sr_q[HDR_BITS-5 -: GBG_BITS];
                            pkt_pay_d   = pay_buf_q;
                        end
                    end
                end
                ST_ACCEPT, ST_ERR: begin
                    state_d    = ST_IDLE;
                    idle_cnt_d = '0;
                end
                default: begin
                    state_d    = ST_IDLE;
                    idle_cnt_d = '0;
                end
            endcase

            // Link-clock watchdog while a frame is open
            if (state_q == ST_HDR || state_q == ST_PAY || state_q == ST_LPAR) begin
                if (samp) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = ST_ERR;
                    rx_error_d = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
        end

        rx_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= ST_IDLE;
            hdr_cnt_q   <= '0;
            hdr_sr_q    <= '0;
            pay_cnt_q   <= '0;
            pay_buf_q   <= '0;
            lane_par_q  <= '0;
            idle_cnt_q  <= '0;
            pkt_valid_q <= 1'b0;
            pkt_type_q  <= PKT_DATA;
            pkt_seq_q   <= 1'b0;
            pkt_gbg_q   <= '0;
            pkt_pay_q   <= '0;
            rx_error_q  <= 1'b0;
            err_code_q  <= ERR_HDR_PARITY;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            hdr_sr_q    <= hdr_sr_d;
            pay_cnt_q   <= pay_cnt_d;
            pay_buf_q   <= pay_buf_d;
            lane_par_q  <= lane_par_d;
            idle_cnt_q  <= idle_cnt_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_type_q  <= pkt_type_d;
            pkt_seq_q   <= pkt_seq_d;
            pkt_gbg_q   <= pkt_gbg_d;
            pkt_pay_q   <= pkt_pay_d;
            rx_error_q  <= rx_error_d;
            err_code_q  <= err_code_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    assign link.pkt_valid   = pkt_valid_q;
    assign link.pkt_type    = pkt_type_q;
    assign link.pkt_seqNum  = pkt_seq_q;
    assign link.pkt_garbage = pkt_gbg_q;
    assign link.pkt_payload = pkt_pay_q;
    assign link.rx_error    = rx_error_q;
    assign link.err_code    = err_code_q;
    assign link.rx_busy     = rx_busy_q;
    assign link.dbg_state   = state_q;

endmodule

// File: tb/tb_packet_receiver.sv
// Directed bench for packet_receiver: drives framed packets on a fast link clock
// and checks decoded outputs, error strobes, latency and timeout behaviour.
module tb_packet_receiver;
    import packet_receiver_pkg::*;

    localparam int H   = 4;     // clk cycles per link-clock half period
    localparam int TMO = 1000;

    logic clk = 1'b0;
    logic rst_l;
    logic game_active;

    packet_receiver_if lk();

    packet_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .game_active (game_active),
        .link        (lk)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int valid_cnt = 0, err_cnt = 0, both_cnt = 0;
    int valid_cyc = 0, err_cyc = 0;

    int                  exp_valid_cnt, exp_err_cnt;
    logic [1:0]          exp_type;
    logic                exp_seq;
    logic [3:0]          exp_gbg;
    logic [1:0]          exp_err_code;
    logic [PAY_BITS-1:0] exp_pl, pl_3, pl_ramp;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lk.pkt_valid) begin valid_cnt <= valid_cnt + 1; valid_cyc <= cyc; end
        if (lk.rx_error)  begin err_cnt   <= err_cnt + 1;   err_cyc   <= cyc; end
        if (lk.pkt_valid && lk.rx_error) both_cnt <= both_cnt + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: observed no end of run, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pl(input string tag, input logic [PAY_BITS-1:0] obs, input logic [PAY_BITS-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One link bit: lanes change with the falling link clock, receiver samples the rise.
    task automatic send_bit(input logic h, input logic [3:0] d);
        lk.gpio_clk_in = 1'b0;
        lk.serial_in_h = h;
        lk.serial_in   = d;
        repeat (H) @(negedge clk);
        lk.gpio_clk_in = 1'b1;
        last_rise_cyc  = cyc;
        repeat (H) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [1:0] t, input logic s, input logic [3:0] g,
                            input logic par_flip, input logic stop_val);
        logic [6:0] body;
        body = {t, s, g};
        send_bit(1'b0, 4'h0);
        for (int i = 6; i >= 0; i--) send_bit(body[i], 4'h0);
        send_bit((^body) ^ par_flip, 4'h0);
        send_bit(stop_val, 4'h0);
    endtask

    task automatic send_payload(input logic [PAY_BITS-1:0] pl, input int n_samps, input logic [3:0] flip);
        logic [3:0] par;
        par = 4'h0;
        for (int i = 0; i < n_samps; i++) begin
            par = par ^ pl[4*i +: 4];
            send_bit(1'b1, pl[4*i +: 4]);
        end
        if (n_samps == LANE_BITS) send_bit(1'b1, par ^ flip);
    endtask

    task automatic check_state(input string tag);
        repeat (4) @(negedge clk);
        chk({tag, "_valid_cnt"}, valid_cnt, exp_valid_cnt);
        chk({tag, "_err_cnt"}, err_cnt, exp_err_cnt);
        chk({tag, "_type"}, lk.pkt_type, exp_type);
        chk({tag, "_seq"}, lk.pkt_seqNum, exp_seq);
        chk({tag, "_gbg"}, lk.pkt_garbage, exp_gbg);
        chk({tag, "_err_code"}, lk.err_code, exp_err_code);
        chk({tag, "_busy"}, lk.rx_busy, 1'b0);
        chk_pl({tag, "_payload"}, lk.pkt_payload, exp_pl);
    endtask

    initial begin
        int lat, e0;
        rst_l          = 1'b0;
        game_active    = 1'b1;
        lk.gpio_clk_in = 1'b0;
        lk.serial_in_h = 1'b1;
        lk.serial_in   = 4'h0;
        exp_valid_cnt  = 0;
        exp_err_cnt    = 0;
        exp_type       = 2'b00;
        exp_seq        = 1'b0;
        exp_gbg        = 4'h0;
        exp_err_code   = 2'b00;
        exp_pl         = '0;
        pl_3           = {LANE_BITS{4'h3}};
        for (int i = 0; i < LANE_BITS; i++) pl_ramp[4*i +: 4] = 4'((i * 7 + 1) % 16);

        repeat (3) @(negedge clk);
        chk("rst_valid", lk.pkt_valid, 1'b0);
        chk("rst_error", lk.rx_error, 1'b0);
        chk("rst_busy", lk.rx_busy, 1'b0);
        chk("rst_state", lk.dbg_state, ST_IDLE);
        chk("rst_type", lk.pkt_type, 2'b00);
        chk_pl("rst_payload", lk.pkt_payload, '0);
        rst_l = 1'b1;
        repeat (3) @(negedge clk);

        // ACK seq=1 garbage=0
        send_hdr(2'b01, 1'b1, 4'h0, 1'b0, 1'b1);
        lat = valid_cyc - last_rise_cyc;
        chk("ack_latency_1to4", (lat >= 1 && lat <= 4), 1'b1);
        exp_valid_cnt++; exp_type = 2'b01; exp_seq = 1'b1; exp_gbg = 4'h0;
        check_state("ack");

        // DATA, every tile 3
        send_hdr(2'b00, 1'b0, 4'h5, 1'b0, 1'b1);
        send_payload(pl_3, LANE_BITS, 4'h0);
        exp_valid_cnt++; exp_type = 2'b00; exp_seq = 1'b0; exp_gbg = 4'h5; exp_pl = pl_3;
        check_state("data3");

        // DATA, distinct tiles so nibble placement is visible
        send_hdr(2'b00, 1'b1, 4'hA, 1'b0, 1'b1);
        send_payload(pl_ramp, LANE_BITS, 4'h0);
        exp_valid_cnt++; exp_seq = 1'b1; exp_gbg = 4'hA; exp_pl = pl_ramp;
        check_state("data_ramp");

        // DATA with lane-2 parity flipped
        send_hdr(2'b00, 1'b0, 4'h5, 1'b0, 1'b1);
        send_payload(pl_3, LANE_BITS, 4'b0100);
        exp_err_cnt++; exp_err_code = 2'b10;
        check_state("lane_par");

        // GAME_LOST with header parity flipped
        send_hdr(2'b11, 1'b1, 4'h9, 1'b1, 1'b1);
        exp_err_cnt++; exp_err_code = 2'b00;
        check_state("hdr_par");

        // Header lane stuck low: two back-to-back stop-bit errors
        for (int i = 0; i < 2 * HDR_BITS; i++) send_bit(1'b0, 4'h0);
        exp_err_cnt += 2; exp_err_code = 2'b01;
        check_state("stuck_low");

        // Link clock stops after 50 payload samps
        send_hdr(2'b00, 1'b0, 4'h7, 1'b0, 1'b1);
        send_payload(pl_ramp, 50, 4'h0);
        e0 = err_cnt;
        for (int i = 0; i < TMO + 20 && err_cnt == e0; i++) @(negedge clk);
        chk("tmo_seen", err_cnt - e0, 1);
        lat = err_cyc - last_rise_cyc;
        chk("tmo_latency", (lat >= TMO && lat <= TMO + 4), 1'b1);
        exp_err_cnt++; exp_err_code = 2'b11;
        check_state("timeout");

        send_hdr(2'b01, 1'b0, 4'h3, 1'b0, 1'b1);
        exp_valid_cnt++; exp_type = 2'b01; exp_seq = 1'b0; exp_gbg = 4'h3;
        check_state("ack_after_tmo");

        // Stop bit driven 0
        send_hdr(2'b01, 1'b1, 4'h6, 1'b0, 1'b0);
        exp_err_cnt++; exp_err_code = 2'b01;
        check_state("stop_bit");

        // game_active dropped mid-header
        send_bit(1'b0, 4'h0);
        send_bit(1'b1, 4'h0);
        send_bit(1'b0, 4'h0);
        chk("ga_busy_in_hdr", lk.dbg_state, ST_HDR);
        game_active = 1'b0;
        repeat (2) @(negedge clk);
        chk("ga_state_idle", lk.dbg_state, ST_IDLE);
        game_active = 1'b1;
        check_state("ga_drop");

        send_hdr(2'b10, 1'b0, 4'h2, 1'b0, 1'b1);
        exp_valid_cnt++; exp_type = 2'b10; exp_seq = 1'b0; exp_gbg = 4'h2;
        check_state("rdy_after_ga");

        // Async reset mid-payload
        send_hdr(2'b00, 1'b1, 4'hC, 1'b0, 1'b1);
        send_payload(pl_3, 20, 4'h0);
        chk("mid_pay_state", lk.dbg_state, ST_PAY);
        rst_l = 1'b0;
        #1;
        chk("arst_state", lk.dbg_state, ST_IDLE);
        chk("arst_busy", lk.rx_busy, 1'b0);
        chk("arst_gbg", lk.pkt_garbage, 4'h0);
        chk("arst_err_code", lk.err_code, 2'b00);
        chk_pl("arst_payload", lk.pkt_payload, '0);
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        exp_type = 2'b00; exp_seq = 1'b0; exp_gbg = 4'h0; exp_err_code = 2'b00; exp_pl = '0;
        check_state("after_arst");

        send_hdr(2'b10, 1'b1, 4'hF, 1'b0, 1'b1);
        exp_valid_cnt++; exp_type = 2'b10; exp_seq = 1'b1; exp_gbg = 4'hF;
        check_state("rdy_after_rst");

        chk("valid_and_error_overlap", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
